// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: FSM state codes and ball speed format.
// Pure declarations; no timing, no flow control.
// Imported by pong_match_ctrl and its sub-modules.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } match_state_t;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_INIT = 3'd1;

    // Saturating speed step used when a rally crosses a speed-up boundary.
    function automatic logic [SPEED_W-1:0] speed_step(input logic [SPEED_W-1:0] cur,
                                                      input logic [SPEED_W-1:0] ceiling);
        return (cur < ceiling) ? cur + 1'b1 : cur;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer for an asynchronous push-button plus registered rising-edge pulse.
// Latency: 3 clocks from key to pulse (two sync stages + edge register).
// No backpressure: pulse is one clock wide per press.
module key_edge (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            sync_1   <= key;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
            pulse    <= sync_2 & ~sync_2_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/rally/point/game-over flow, scores, ball gating and speed-up.
// Latency: all outputs registered, one clock after the causing input; start is 4 clocks after start_key.
// No backpressure; PONG_SPEEDUP_EN enables hit counting and speed escalation (else speed fixed at 1).
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE        = 7,
    parameter int SCORE_W          = 4,
    parameter int SERVE_FRAMES     = 60,
    parameter int POINT_FRAMES     = 90,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SPEED_MAX        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_key,
    input  logic               miss_top,
    input  logic               miss_bottom,
    input  logic               paddle_hit,
    output logic               ball_run,
    output logic               ball_recentre,
    output logic               serve_down,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score_top,
    output logic [SCORE_W-1:0] score_bottom,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int FRAME_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    logic start;

    key_edge u_start_edge (
        .clock (clock),
        .reset (reset),
        .key   (start_key),
        .pulse (start)
    );

    match_state_t       fsm;
    logic [FRAME_W-1:0] frame_cnt;

    // Simultaneous misses cancel each other; any miss masks a paddle hit.
    logic point_bottom;
    logic point_top;
    logic any_miss;

    assign point_bottom = miss_top & ~miss_bottom;
    assign point_top    = miss_bottom & ~miss_top;
    assign any_miss     = miss_top | miss_bottom;

`ifdef PONG_SPEEDUP_EN
    localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);

    logic [HIT_W-1:0]   hit_cnt;
    logic [SPEED_W-1:0] speed_q;

    assign speed = speed_q;
`else
    logic unused_paddle_hit;

    assign speed             = SPEED_INIT;
    assign unused_paddle_hit = paddle_hit;
`endif

    assign state = fsm;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm           <= IDLE;
            frame_cnt     <= '0;
            ball_run      <= 1'b0;
            ball_recentre <= 1'b0;
            serve_down    <= 1'b1;
            score_top     <= '0;
            score_bottom  <= '0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
`ifdef PONG_SPEEDUP_EN
            hit_cnt       <= '0;
            speed_q       <= SPEED_INIT;
`endif
        end else begin
            ball_recentre <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        score_top     <= '0;
                        score_bottom  <= '0;
                        ball_recentre <= 1'b1;
                        frame_cnt     <= '0;
                        fsm           <= SERVE;
`ifdef PONG_SPEEDUP_EN
                        hit_cnt       <= '0;
                        speed_q       <= SPEED_INIT;
`endif
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == FRAME_W'(SERVE_FRAMES - 1)) begin
                            frame_cnt <= '0;
                            ball_run  <= 1'b1;
                            fsm       <= PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (point_bottom || point_top) begin
                        ball_run  <= 1'b0;
                        frame_cnt <= '0;
                        if (point_bottom) begin
                            score_bottom <= score_bottom + 1'b1;
                            serve_down   <= 1'b0;
                        end else begin
                            score_top    <= score_top + 1'b1;
                            serve_down   <= 1'b1;
                        end
                        if ((point_bottom && (score_bottom + 1'b1 == SCORE_W'(WIN_SCORE))) ||
                            (point_top && (score_top + 1'b1 == SCORE_W'(WIN_SCORE)))) begin
                            game_over <= 1'b1;
                            winner    <= point_bottom;
                            fsm       <= OVER;
                        end else begin
                            fsm       <= POINT;
                        end
                    end
`ifdef PONG_SPEEDUP_EN
                    else if (paddle_hit && !any_miss) begin
                        if (hit_cnt == HIT_W'(HITS_PER_SPEEDUP - 1)) begin
                            hit_cnt <= '0;
                            speed_q <= speed_step(speed_q, SPEED_W'(SPEED_MAX));
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
`endif
                end
                POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == FRAME_W'(POINT_FRAMES - 1)) begin
                            frame_cnt     <= '0;
                            ball_recentre <= 1'b1;
                            fsm           <= SERVE;
`ifdef PONG_SPEEDUP_EN
                            hit_cnt       <= '0;
                            speed_q       <= SPEED_INIT;
`endif
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (start) begin
                        score_top     <= '0;
                        score_bottom  <= '0;
                        game_over     <= 1'b0;
                        winner        <= 1'b0;
                        serve_down    <= 1'b1;
                        ball_recentre <= 1'b1;
                        frame_cnt     <= '0;
                        fsm           <= SERVE;
`ifdef PONG_SPEEDUP_EN
                        hit_cnt       <= '0;
                        speed_q       <= SPEED_INIT;
`endif
                    end
                end
                default: begin
                    fsm      <= IDLE;
                    ball_run <= 1'b0;
                end
            endcase
        end
    end

endmodule
